// File: rtl/note_sequencer.sv
// note_sequencer: programmable step sequencer feeding the synth voice.
// A small step table holds {osc_count, length, gate} per entry; the
// sequencer walks it at a fixed tick rate and loops while run is high.
module note_sequencer #(
    parameter int STEPS    = 16,
    parameter int AW       = 4,
    parameter int TICK_DIV = 20480
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_count,
    input  logic [7:0]    wr_len,
    input  logic [7:0]    wr_gate,
    input  logic          run,
    input  logic [AW-1:0] loop_len,
    output logic          trig,
    output logic [31:0]   osc_count,
    output logic [AW-1:0] step,
    output logic          busy
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [AW-1:0] step_reg, step_next;
    logic          trig_reg, trig_next;
    logic [31:0]   osc_reg, osc_next;
    logic [PW-1:0] presc_reg, presc_next;
    logic [7:0]    ticks_reg, ticks_next;
    logic [7:0]    len_reg, len_next;
    logic [7:0]    gate_reg, gate_next;

    // Step table: {count[31:0], len[7:0], gate[7:0]}
    logic [47:0]   table_mem [STEPS];
    logic [47:0]   rd_data_reg;
    logic [AW-1:0] rd_addr;

    logic [31:0]   rd_count;
    logic [7:0]    rd_len;
    logic [7:0]    rd_gate;

    logic [AW-1:0] adv_step;
    logic          tick_wrap;
    logic [7:0]    ticks_inc;

    assign rd_count = rd_data_reg[47:16];
    assign rd_len   = rd_data_reg[15:8];
    assign rd_gate  = rd_data_reg[7:0];

    // The table is addressed with the step that will be current next cycle,
    // so the entry is already registered when the FSM sits in LOAD.
    assign rd_addr = step_next;

    // Table write port plus registered read; the read sees the pre-write
    // contents when both hit the same entry in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STEPS; i++) begin
                table_mem[i] <= '0;
            end
            rd_data_reg <= '0;
        end else begin
            if (wr_en) begin
                table_mem[wr_addr] <= {wr_count, wr_len, wr_gate};
            end
            rd_data_reg <= table_mem[rd_addr];
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            step_reg  <= '0;
            trig_reg  <= 1'b0;
            osc_reg   <= '0;
            presc_reg <= '0;
            ticks_reg <= '0;
            len_reg   <= '0;
            gate_reg  <= '0;
        end else begin
            state_reg <= state_next;
            step_reg  <= step_next;
            trig_reg  <= trig_next;
            osc_reg   <= osc_next;
            presc_reg <= presc_next;
            ticks_reg <= ticks_next;
            len_reg   <= len_next;
            gate_reg  <= gate_next;
        end
    end

    assign adv_step  = (step_reg == loop_len) ? '0 : step_reg + AW'(1);
    assign tick_wrap = (presc_reg == PW'(TICK_DIV - 1));
    assign ticks_inc = ticks_reg + 8'd1;

    // Next-state logic: IDLE -> LOAD -> PLAY -> LOAD ... -> IDLE.
    always_comb begin
        state_next = state_reg;
        step_next  = step_reg;
        trig_next  = trig_reg;
        osc_next   = osc_reg;
        presc_next = presc_reg;
        ticks_next = ticks_reg;
        len_next   = len_reg;
        gate_next  = gate_reg;

        case (state_reg)
            IDLE: begin
                trig_next = 1'b0;
                if (run) begin
                    state_next = LOAD;
                    step_next  = '0;
                end
            end

            LOAD: begin
                trig_next = 1'b0;
                if (rd_len == 8'd0) begin
                    // A skipped entry is a zero-length step: it advances the
                    // index, and honours run like any step end so that an
                    // all-skip table can still be stopped.
                    if (run) begin
                        step_next = adv_step;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    // Length and gate are latched so table writes during the
                    // step only take effect the next time this entry loads.
                    state_next = PLAY;
                    osc_next   = rd_count;
                    presc_next = '0;
                    ticks_next = '0;
                    len_next   = rd_len;
                    gate_next  = rd_gate;
                    trig_next  = (rd_gate != 8'd0);
                end
            end

            PLAY: begin
                if (tick_wrap) begin
                    presc_next = '0;
                    ticks_next = ticks_inc;
                    if (ticks_inc == gate_reg) begin
                        trig_next = 1'b0;
                    end
                    if (ticks_inc == len_reg) begin
                        trig_next = 1'b0;
                        if (run) begin
                            state_next = LOAD;
                            step_next  = adv_step;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end else begin
                    presc_next = presc_reg + PW'(1);
                end
            end

            default: begin
                state_next = IDLE;
                trig_next  = 1'b0;
            end
        endcase
    end

    assign trig      = trig_reg;
    assign osc_count = osc_reg;
    assign step      = step_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer (TICK_DIV=4). The stimulus thread
// queues every expected output change with the cycle gap since the previous
// change; the monitor pops an entry whenever {trig,osc_count,step,busy} moves.
module tb_note_sequencer;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_count;
    logic [7:0]  wr_len;
    logic [7:0]  wr_gate;
    logic        run;
    logic [3:0]  loop_len;
    logic        trig;
    logic [31:0] osc_count;
    logic [3:0]  step;
    logic        busy;

    note_sequencer #(
        .STEPS(16),
        .AW(4),
        .TICK_DIV(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_count(wr_count),
        .wr_len(wr_len),
        .wr_gate(wr_gate),
        .run(run),
        .loop_len(loop_len),
        .trig(trig),
        .osc_count(osc_count),
        .step(step),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        trig;
        logic [31:0] osc;
        logic [3:0]  step;
        logic        busy;
        int          gap;   // -1: gap not checked
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    task automatic push(input logic t, input logic [31:0] o, input logic [3:0] s,
                        input logic b, input int g);
        exp_t e;
        e.trig = t;
        e.osc  = o;
        e.step = s;
        e.busy = b;
        e.gap  = g;
        sb.push_back(e);
    endtask

    // Advance n rising edges, then settle 1 time unit before driving.
    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [3:0] a, input logic [31:0] c,
                               input logic [7:0] l, input logic [7:0] g);
        wr_en    = 1'b1;
        wr_addr  = a;
        wr_count = c;
        wr_len   = l;
        wr_gate  = g;
        wait_edges(1);
        wr_en    = 1'b0;
    endtask

    // Monitor: on every output change, pop the next expectation and compare.
    initial begin
        logic [37:0] cur;
        logic [37:0] prev;
        logic [37:0] req;
        bit          have_prev;
        int          cyc;
        int          last;
        exp_t        e;
        have_prev = 1'b0;
        cyc  = 0;
        last = 0;
        prev = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en) begin
                cur = {trig, osc_count, step, busy};
                if (!have_prev || cur !== prev) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_change cyc=%0d got trig=%b osc=%0d step=%0d busy=%b",
                                 cyc, trig, osc_count, step, busy);
                    end else begin
                        e   = sb.pop_front();
                        req = {e.trig, e.osc, e.step, e.busy};
                        checks++;
                        if (cur !== req) begin
                            errors++;
                            $display("FAIL outputs cyc=%0d got trig=%b osc=%0d step=%0d busy=%b want trig=%b osc=%0d step=%0d busy=%b",
                                     cyc, trig, osc_count, step, busy, e.trig, e.osc, e.step, e.busy);
                        end
                        if (e.gap >= 0 && have_prev) begin
                            checks++;
                            if (cyc - last != e.gap) begin
                                errors++;
                                $display("FAIL gap cyc=%0d got %0d cycles want %0d",
                                         cyc, cyc - last, e.gap);
                            end
                        end
                    end
                    $display("change cyc=%0d trig=%b osc=%0d step=%0d busy=%b",
                             cyc, trig, osc_count, step, busy);
                    have_prev = 1'b1;
                    prev = cur;
                    last = cyc;
                end
            end
        end
    end

    // Stimulus
    initial begin
        wr_en = 1'b0; wr_addr = '0; wr_count = '0; wr_len = '0; wr_gate = '0;
        run = 1'b0; loop_len = '0; rst = 1'b1;

        // Reset with random inputs, including writes that reset must override.
        for (int i = 0; i < 2; i++) begin
            wr_en    = 1'($urandom);
            wr_addr  = 4'($urandom);
            wr_count = $urandom;
            wr_len   = 8'($urandom);
            wr_gate  = 8'($urandom);
            run      = 1'($urandom);
            loop_len = 4'($urandom);
            wait_edges(1);
        end
        rst = 1'b0; wr_en = 1'b0; run = 1'b0; loop_len = 4'd0;
        push(1'b0, 32'd0, 4'd0, 1'b0, -1);
        wait_edges(1);
        mon_en = 1'b1;
        wait_edges(1);

        // Unwritten table: endless skipping in LOAD, trig never rises.
        push(1'b0, 32'd0, 4'd0, 1'b1, -1);
        run = 1'b1;
        wait_edges(12);
        push(1'b0, 32'd0, 4'd0, 1'b0, -1);
        rst = 1'b1; run = 1'b0;
        wait_edges(1);
        rst = 1'b0;
        wait_edges(2);

        // Basic play with a skip and wrap; run dropped at cycle 3 of entry0.
        write_entry(4'd0, 32'd100, 8'd3, 8'd2);
        write_entry(4'd1, 32'd200, 8'd2, 8'd5);
        write_entry(4'd2, 32'd0,   8'd0, 8'd0);
        loop_len = 4'd2;
        push(1'b0, 32'd0,   4'd0, 1'b1, -1);
        push(1'b1, 32'd100, 4'd0, 1'b1, 1);
        push(1'b0, 32'd100, 4'd0, 1'b1, 8);
        push(1'b0, 32'd100, 4'd1, 1'b1, 4);
        push(1'b1, 32'd200, 4'd1, 1'b1, 1);
        push(1'b0, 32'd200, 4'd2, 1'b1, 8);
        push(1'b0, 32'd200, 4'd0, 1'b1, 1);
        push(1'b1, 32'd100, 4'd0, 1'b1, 1);
        push(1'b0, 32'd100, 4'd0, 1'b1, 8);
        push(1'b0, 32'd100, 4'd0, 1'b0, 4);
        wait_edges(1);
        run = 1'b1;
        wait_edges(27);
        run = 1'b0;
        wait_edges(15);

        // Rest step: gate 0 keeps trig low for the whole step.
        write_entry(4'd0, 32'd300, 8'd2, 8'd0);
        loop_len = 4'd0;
        push(1'b0, 32'd100, 4'd0, 1'b1, -1);
        push(1'b0, 32'd300, 4'd0, 1'b1, 1);
        push(1'b0, 32'd300, 4'd0, 1'b0, 8);
        wait_edges(1);
        run = 1'b1;
        wait_edges(3);
        run = 1'b0;
        wait_edges(12);

        // Skip leaves osc_count alone; rst mid-PLAY with trig high.
        write_entry(4'd0, 32'd0,   8'd0, 8'd0);
        write_entry(4'd1, 32'd400, 8'd4, 8'd4);
        loop_len = 4'd1;
        push(1'b0, 32'd300, 4'd0, 1'b1, -1);
        push(1'b0, 32'd300, 4'd1, 1'b1, 1);
        push(1'b1, 32'd400, 4'd1, 1'b1, 1);
        push(1'b0, 32'd0,   4'd0, 1'b0, 3);
        wait_edges(1);
        run = 1'b1;
        wait_edges(5);
        rst = 1'b1; run = 1'b0;
        wait_edges(1);
        rst = 1'b0; loop_len = 4'd0;
        wait_edges(2);

        // Restart after reset: table is zeroed, trig stays low.
        push(1'b0, 32'd0, 4'd0, 1'b1, -1);
        run = 1'b1;
        wait_edges(12);
        push(1'b0, 32'd0, 4'd0, 1'b0, -1);
        rst = 1'b1; run = 1'b0;
        wait_edges(1);
        rst = 1'b0;
        wait_edges(2);

        // Writes while playing: entry1 updated mid-step, entry0 rewritten
        // across its read/LOAD cycles (old value plays, new one next loop).
        write_entry(4'd0, 32'd100, 8'd2, 8'd1);
        loop_len = 4'd1;
        push(1'b0, 32'd0,   4'd0, 1'b1, -1);
        push(1'b1, 32'd100, 4'd0, 1'b1, 1);
        push(1'b0, 32'd100, 4'd0, 1'b1, 4);
        push(1'b0, 32'd100, 4'd1, 1'b1, 4);
        push(1'b1, 32'd555, 4'd1, 1'b1, 1);
        push(1'b0, 32'd555, 4'd0, 1'b1, 4);
        push(1'b1, 32'd100, 4'd0, 1'b1, 1);
        push(1'b0, 32'd100, 4'd0, 1'b1, 4);
        push(1'b0, 32'd100, 4'd1, 1'b1, 4);
        push(1'b1, 32'd555, 4'd1, 1'b1, 1);
        push(1'b0, 32'd555, 4'd0, 1'b1, 4);
        push(1'b1, 32'd700, 4'd0, 1'b1, 1);
        push(1'b0, 32'd700, 4'd0, 1'b0, 4);
        wait_edges(1);
        run = 1'b1;
        wait_edges(3);
        wr_en = 1'b1; wr_addr = 4'd1; wr_count = 32'd555; wr_len = 8'd1; wr_gate = 8'd1;
        wait_edges(1);
        wr_en = 1'b0;
        wait_edges(10);
        wr_en = 1'b1; wr_addr = 4'd0; wr_count = 32'd700; wr_len = 8'd1; wr_gate = 8'd1;
        wait_edges(2);
        wr_en = 1'b0;
        wait_edges(14);
        run = 1'b0;
        wait_edges(8);

        // Every queued change must have been observed.
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
